multdiv_ctrl: RTL

Iterative signed 32-bit multiply/divide sequencer for the execute stage. It captures operands on a start pulse and runs 32 radix-2 iterations: shift-add for multiply, restoring subtract-compare for divide. It then sign-corrects and reports `result`/`exception` with a one-cycle ready pulse. The pipeline stalls on `busy` while the ALU handles single-cycle operations.

---
 rtl/multdiv_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply/divide sequencer: shift-add multiply, restoring divide, WIDTH iterations.
// Optional MULTDIV_EARLY_DIV0_EN: a divide by zero skips the iterations and reports at the next edge.
module multdiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    logic [WIDTH:0]     magA;
    logic [WIDTH:0]     magB;
    logic               isDiv;
    logic               signA;
    logic               signB;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   iterCnt;

    logic [WIDTH:0]     opMagA;
    logic [WIDTH:0]     opMagB;
    logic               earlyDiv0;
    logic [WIDTH:0]     mulSum;
    logic [ACC_W-1:0]   divShift;
    logic [WIDTH+1:0]   divDiff;
    logic               negRes;
    logic [PROD_W-1:0]  prodSigned;
    logic [WIDTH-1:0]   quoSigned;
    logic               mulOvf;
    logic               divOvf;
    logic [WIDTH-1:0]   fixResult;
    logic               fixExc;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) in WIDTH+1 bits
    always_comb begin
        opMagA = data_operandA[WIDTH-1] ? {1'b0, ~data_operandA + WIDTH'(1)} : {1'b0, data_operandA};
        opMagB = data_operandB[WIDTH-1] ? {1'b0, ~data_operandB + WIDTH'(1)} : {1'b0, data_operandB};
`ifdef MULTDIV_EARLY_DIV0_EN
        earlyDiv0 = ctrl_DIV && !ctrl_MULT && (data_operandB == '0);
`else
        earlyDiv0 = 1'b0;
`endif
    end

    // Per-iteration datapath: upper accumulator half is partial product or remainder
    always_comb begin
        mulSum   = acc[ACC_W-1:WIDTH] + magA;
        divShift = {acc[ACC_W-2:0], 1'b0};
        divDiff  = {1'b0, divShift[ACC_W-1:WIDTH]} - {1'b0, magB};
    end

    // Sign correction and exception detection for the FIX state
    always_comb begin
        negRes     = signA ^ signB;
        prodSigned = negRes ? ~acc[PROD_W-1:0] + PROD_W'(1) : acc[PROD_W-1:0];
        quoSigned  = negRes ? ~acc[WIDTH-1:0] + WIDTH'(1) : acc[WIDTH-1:0];
        mulOvf     = !((&prodSigned[PROD_W-1:WIDTH-1]) || !(|prodSigned[PROD_W-1:WIDTH-1]));
        divOvf     = !negRes && acc[WIDTH-1];
        fixResult  = prodSigned[WIDTH-1:0];
        fixExc     = mulOvf;
        if (isDiv) begin
            if (magB == '0) begin
                fixResult = '0;
                fixExc    = 1'b1;
            end else begin
                fixResult = quoSigned;
                fixExc    = divOvf;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            magA           <= '0;
            magB           <= '0;
            isDiv          <= 1'b0;
            signA          <= 1'b0;
            signB          <= 1'b0;
            acc            <= '0;
            iterCnt        <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ctrl_MULT || ctrl_DIV) begin
                        magA    <= opMagA;
                        magB    <= opMagB;
                        isDiv   <= !ctrl_MULT;
                        signA   <= data_operandA[WIDTH-1];
                        signB   <= data_operandB[WIDTH-1];
                        // Low half starts as multiplier (multiply) or dividend (divide)
                        acc     <= {(WIDTH+1)'(0), ctrl_MULT ? opMagB[WIDTH-1:0] : opMagA[WIDTH-1:0]};
                        iterCnt <= '0;
                        busy    <= 1'b1;
                        state   <= earlyDiv0 ? FIX : RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (isDiv) begin
                        acc <= divDiff[WIDTH+1] ? divShift
                                                : {divDiff[WIDTH:0], divShift[WIDTH-1:1], 1'b1};
                    end else begin
                        acc <= {1'b0, acc[0] ? mulSum : acc[ACC_W-1:WIDTH], acc[WIDTH-1:1]};
                    end
                    iterCnt <= iterCnt + CNT_W'(1);
                    if (iterCnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    data_result    <= fixResult;
                    data_exception <= fixExc;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state          <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
